gray_step_monitor: RTL and testbench

- Sits directly downstream of the gray-code counter and watches its output every clock.
- Decodes each sampled gray value to binary.
- Checks every step against the counter's enable:
  - exactly +1 (single-bit flip) when the counter was enabled;
  - no change when it was not.
- Flags, classifies and counts illegal transitions (hazards) for the hazard-detection datapath.

---
 rtl/gray_step_monitor.sv | 104 ++++++++++
 tb/tb_gray_step_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - checks each gray-counter step against its enable and tracks hazards
module gray_step_monitor #(
  parameter int M     = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [M-1:0]     gray_code,
  input  logic             clear,
  output logic [M-1:0]     bin_code,
  output logic             hazard,
  output logic [1:0]       hazard_type,
  output logic             hazard_sticky,
  output logic [ERR_W-1:0] hazard_count,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic [1:0] T_LEGAL  = 2'b00;
  localparam logic [1:0] T_UNEXP  = 2'b01;
  localparam logic [1:0] T_MULTI  = 2'b10;
  localparam logic [1:0] T_WRONG  = 2'b11;

  localparam logic [ERR_W-1:0] COUNT_MAX = {ERR_W{1'b1}};

  function automatic logic [M-1:0] gray2bin(input logic [M-1:0] g);
    logic [M-1:0] b;
    b[M-1] = g[M-1];
    for (int i = M - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [M-1:0] prev_gray;
  logic         en_d;
  logic [M-1:0] diff;
  logic         multi_flip;
  logic [1:0]   step_type;

  // Clearing the lowest set bit leaves something only when two or more bits flipped.
  always_comb begin
    diff       = gray_code ^ prev_gray;
    multi_flip = (diff & (diff - M'(1))) != '0;
    step_type  = T_LEGAL;
    if (!en_d && diff != '0) begin
      step_type = T_UNEXP;
    end else if (multi_flip) begin
      step_type = T_MULTI;
    end else if (en_d && gray2bin(gray_code) != gray2bin(prev_gray) + M'(1)) begin
      step_type = T_WRONG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray     <= '0;
      en_d          <= 1'b0;
      bin_code      <= '0;
      hazard        <= 1'b0;
      hazard_type   <= T_LEGAL;
      hazard_sticky <= 1'b0;
      hazard_count  <= '0;
      state         <= ST_INIT;
    end else begin
      prev_gray <= gray_code;
      en_d      <= enable;
      bin_code  <= gray2bin(gray_code);

      if (clear) begin
        hazard        <= 1'b0;
        hazard_type   <= T_LEGAL;
        hazard_sticky <= 1'b0;
        hazard_count  <= '0;
        state         <= ST_INIT;
      end else begin
        case (state)
          ST_TRACK, ST_FAULT: begin
            hazard_type <= step_type;
            hazard      <= (step_type != T_LEGAL);
            if (step_type != T_LEGAL) begin
              hazard_sticky <= 1'b1;
              state         <= ST_FAULT;
              if (hazard_count != COUNT_MAX) begin
                hazard_count <= hazard_count + ERR_W'(1);
              end
            end
          end
          // INIT only primes prev_gray; the unused encoding also recovers here.
          default: begin
            hazard      <= 1'b0;
            hazard_type <= T_LEGAL;
            state       <= ST_TRACK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - randomized and directed bench for gray_step_monitor against a behavioural model
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] gray_code = 3'd0;
  logic       clear = 1'b0;

  logic [2:0] bin_code, bin_code2;
  logic       hazard, hazard2;
  logic [1:0] hazard_type, hazard_type2;
  logic       hazard_sticky, hazard_sticky2;
  logic [7:0] hazard_count;
  logic [1:0] hazard_count2;
  logic [1:0] state, state2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_step_monitor #(.M(3), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .gray_code(gray_code), .clear(clear),
    .bin_code(bin_code), .hazard(hazard), .hazard_type(hazard_type),
    .hazard_sticky(hazard_sticky), .hazard_count(hazard_count), .state(state)
  );

  gray_step_monitor #(.M(3), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .gray_code(gray_code), .clear(clear),
    .bin_code(bin_code2), .hazard(hazard2), .hazard_type(hazard_type2),
    .hazard_sticky(hazard_sticky2), .hazard_count(hazard_count2), .state(state2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: binary value found by searching the gray table.
  function automatic int to_bin(input int g);
    for (int b = 0; b < 8; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  function automatic int ones(input int v);
    int n = 0;
    for (int i = 0; i < 3; i++) n += (v >> i) & 1;
    return n;
  endfunction

  int m_prev = 0, m_en_d = 0, m_mode = 0, m_cnt8 = 0, m_cnt2 = 0;
  int m_sticky = 0, m_haz = 0, m_type = 0, m_bin = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_en_d = 0; m_mode = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_sticky = 0; m_haz = 0; m_type = 0; m_bin = 0;
    end else begin
      int g, d, t;
      g = int'(gray_code);
      d = g ^ m_prev;
      if (m_en_d == 0 && d != 0) t = 1;
      else if (ones(d) > 1) t = 2;
      else if (m_en_d == 1 && to_bin(g) != (to_bin(m_prev) + 1) % 8) t = 3;
      else t = 0;
      if (clear) begin
        m_haz = 0; m_type = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        m_haz = 0; m_type = 0; m_mode = 1;
      end else begin
        m_type = t;
        m_haz = (t != 0) ? 1 : 0;
        if (t != 0) begin
          m_sticky = 1;
          m_mode = 2;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      m_prev = g;
      m_en_d = int'(enable);
      m_bin = to_bin(g);
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model bin_code", int'(bin_code), m_bin);
      chk("model hazard", int'(hazard), m_haz);
      chk("model hazard_type", int'(hazard_type), m_type);
      chk("model hazard_sticky", int'(hazard_sticky), m_sticky);
      chk("model hazard_count", int'(hazard_count), m_cnt8);
      chk("model state", int'(state), m_mode);
      chk("model hazard_count w2", int'(hazard_count2), m_cnt2);
      chk("model hazard w2", int'(hazard2), m_haz);
    end
  end

  // Apply inputs, let one rising edge consume them, return at edge+2.
  task automatic drive(input bit e, input int g, input bit c);
    enable = e;
    gray_code = 3'(g);
    clear = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int c, g, pe;
    #1 rst_n = 1'b0;
    #2;
    chk("reset bin_code", int'(bin_code), 0);
    chk("reset hazard", int'(hazard), 0);
    chk("reset count", int'(hazard_count), 0);
    chk("reset state", int'(state), 0);
    cmp_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Real counter sequence including wrap 100 -> 000.
    drive(1, 0, 0);
    chk("init to track", int'(state), 1);
    for (int i = 1; i <= 18; i++) begin
      drive(i != 18, (i % 8) ^ ((i % 8) >> 1), 0);
      chk("count bin_code", int'(bin_code), i % 8);
      chk("count hazard", int'(hazard), 0);
    end
    chk("count state track", int'(state), 1);

    for (int i = 0; i < 5; i++) begin
      drive(0, 3, 0);
      chk("hold type", int'(hazard_type), 0);
    end
    drive(0, 1, 0);
    chk("unexp hazard", int'(hazard), 1);
    chk("unexp type", int'(hazard_type), 1);
    chk("unexp count", int'(hazard_count), 1);
    chk("unexp sticky", int'(hazard_sticky), 1);
    chk("unexp state", int'(state), 2);
    chk("sat w2 1", int'(hazard_count2), 1);
    drive(1, 0, 0);
    chk("unexp2 type", int'(hazard_type), 1);
    chk("sat w2 2", int'(hazard_count2), 2);
    drive(1, 3, 0);
    chk("multi type", int'(hazard_type), 2);
    chk("sat w2 3", int'(hazard_count2), 3);
    drive(1, 1, 0);
    chk("wrong dir type", int'(hazard_type), 3);
    chk("sat w2 3b", int'(hazard_count2), 3);
    drive(1, 1, 0);
    chk("stuck type", int'(hazard_type), 3);
    chk("sat w2 3c", int'(hazard_count2), 3);
    chk("count 5", int'(hazard_count), 5);
    drive(1, 3, 0);
    chk("legal in fault hazard", int'(hazard), 0);
    chk("legal in fault type", int'(hazard_type), 0);
    chk("fault held", int'(state), 2);
    drive(0, 2, 0);
    chk("fault held 2", int'(state), 2);
    chk("sticky held w2", int'(hazard_sticky2), 1);

    // Clear on the same edge as a multi-bit flip.
    drive(0, 5, 1);
    chk("clear hazard", int'(hazard), 0);
    chk("clear count", int'(hazard_count), 0);
    chk("clear sticky", int'(hazard_sticky), 0);
    chk("clear state", int'(state), 0);
    chk("clear bin_code", int'(bin_code), 6);
    drive(1, 5, 0);
    chk("after clear state", int'(state), 1);
    drive(0, 4, 0);
    chk("after clear type", int'(hazard_type), 0);
    chk("after clear hazard", int'(hazard), 0);

    // Randomized counter with occasional corruption and clears.
    c = 7; pe = 0;
    for (int i = 0; i < 400; i++) begin
      if (pe != 0) c = (c + 1) % 8;
      g = c ^ (c >> 1);
      if ($urandom % 5 == 0) begin
        g = int'($urandom % 8);
        c = to_bin(g);
      end
      pe = int'($urandom % 2);
      drive(pe != 0, g, ($urandom % 25) == 0);
    end

    // Asynchronous reset pulse between edges.
    #1 rst_n = 1'b0;
    #1;
    chk("async hazard_count", int'(hazard_count), 0);
    chk("async state", int'(state), 0);
    chk("async bin_code", int'(bin_code), 0);
    chk("async sticky", int'(hazard_sticky), 0);
    #1;
    gray_code = 3'd6;
    enable = 1'b0;
    clear = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post reset edge1 hazard", int'(hazard), 0);
    chk("post reset edge1 state", int'(state), 1);
    drive(0, 6, 0);
    chk("post reset edge2 hazard", int'(hazard), 0);
    chk("post reset edge2 state", int'(state), 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
